// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared definitions for the byte-serial adder sequencer: state encoding and index sizing.
package byte_serial_adder_ctrl_pkg;

    localparam int unsigned BSA_STATE_W = 2;

    localparam logic [BSA_STATE_W-1:0] BSA_IDLE = 2'd0;
    localparam logic [BSA_STATE_W-1:0] BSA_ADD  = 2'd1;
    localparam logic [BSA_STATE_W-1:0] BSA_DONE = 2'd2;

    // Ceiling log2, never less than 1 so a single-byte build still has an index bit.
    function automatic int unsigned bsa_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/byte_serial_adder_ctrl_cla.sv
// Existing 8-bit carry look-ahead adder shared by the team's datapaths.
module Carry_Look_Ahead_Adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry chain from generate/propagate terms.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial wide adder: one byte per clock through a shared 8-bit CLA, LSB first.
// Optional feature macro: BSA_SUB_EN (adds the op port for subtraction).
module byte_serial_adder_ctrl
    import byte_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef BSA_SUB_EN
    input  logic                  op,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IDXW = bsa_clog2(NBYTES);

    logic [BSA_STATE_W-1:0] state_q;
    logic [BSA_STATE_W-1:0] state_d;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [W-1:0]           sum_q;
    logic                   carry_q;
    logic [IDXW-1:0]        idx_q;
`ifdef BSA_SUB_EN
    logic                   op_q;
`endif

    logic                   accept_c;
    logic                   last_c;
    logic [7:0]             a_byte_c;
    logic [7:0]             b_byte_c;
    logic [7:0]             cla_sum_c;
    logic                   cla_cout_c;

    assign in_ready  = (state_q == BSA_IDLE) || ((state_q == BSA_DONE) && out_ready);
    assign accept_c  = in_valid && in_ready;
    assign last_c    = (idx_q == IDXW'(NBYTES - 1));
    assign out_valid = (state_q == BSA_DONE);
    assign busy      = (state_q == BSA_ADD);
    assign sum       = sum_q;
    assign cout      = carry_q;

    assign a_byte_c = a_q[8*int'(idx_q) +: 8];
`ifdef BSA_SUB_EN
    assign b_byte_c = op_q ? ~b_q[8*int'(idx_q) +: 8] : b_q[8*int'(idx_q) +: 8];
`else
    assign b_byte_c = b_q[8*int'(idx_q) +: 8];
`endif

    Carry_Look_Ahead_Adder_8bit u_cla (
        .a    (a_byte_c),
        .b    (b_byte_c),
        .cin  (carry_q),
        .sum  (cla_sum_c),
        .cout (cla_cout_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BSA_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: DONE may chain straight into ADD when a new operand set arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BSA_IDLE: if (accept_c) state_d = BSA_ADD;
            BSA_ADD:  if (last_c)   state_d = BSA_DONE;
            BSA_DONE: begin
                if (accept_c)       state_d = BSA_ADD;
                else if (out_ready) state_d = BSA_IDLE;
            end
            default:                state_d = BSA_IDLE;
        endcase
    end

    // Operand capture on accept, then one byte of sum and the carry per ADD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef BSA_SUB_EN
            op_q    <= 1'b0;
`endif
        end else if (accept_c) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
`ifdef BSA_SUB_EN
            op_q    <= op;
            carry_q <= op ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
        end else if (state_q == BSA_ADD) begin
            sum_q[8*int'(idx_q) +: 8] <= cla_sum_c;
            carry_q                   <= cla_cout_c;
            if (!last_c) idx_q <= idx_q + IDXW'(1);
        end
    end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for byte_serial_adder_ctrl (NBYTES=4) with a transaction-level reference model.
module tb_byte_serial_adder_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef BSA_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of a whole wide operation, {cout, sum}.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic o);
        if (o) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Transaction model: cycles left in the add, result pending, last presented result.
    int         m_left = 0;
    bit         m_done = 1'b0;
    logic [W:0] m_cur  = '0;
    logic [W:0] m_last = '0;

    always @(posedge clk or posedge rst) begin
        int         nl;
        bit         nd;
        bit         acc;
        logic [W:0] nc;
        logic [W:0] nlast;
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_last <= '0;
        end else begin
            nl    = m_left;
            nd    = m_done;
            nc    = m_cur;
            nlast = m_last;
            acc   = in_valid && (m_left == 0) && (!m_done || out_ready);
            if (m_done && out_ready) nd = 1'b0;
            if (nl > 0) begin
                nl--;
                if (nl == 0) begin
                    nd    = 1'b1;
                    nlast = m_cur;
                end
            end
            if (acc) begin
                nl = NB;
                nc = ref_op(a, b, cin, op);
            end
            m_left <= nl;
            m_done <= nd;
            m_cur  <= nc;
            m_last <= nlast;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_in_ready", 64'(in_ready), 64'((m_left == 0) && (!m_done || out_ready)));
            chk("model_out_valid", 64'(out_valid), 64'(m_done));
            chk("model_busy", 64'(busy), 64'(m_left > 0));
            if (m_left == 0) begin
                chk("model_sum", 64'(sum), 64'(m_last[W-1:0]));
                chk("model_cout", 64'(cout), 64'(m_last[W]));
            end
        end
    end

    // Present one operand set, then wait for its result; lat counts edges after accept.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic o, output int lat);
        int n;
        n = 0;
        a = x; b = y; cin = ci; op = o; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    initial begin
        int lat;
        int n;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        rst = 1'b0;

        // Carry ripples through every byte.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        chk("ripple_latency", 64'(lat), 64'(4));
        chk("ripple_sum", 64'(sum), 64'h0000_0000);
        chk("ripple_cout", 64'(cout), 64'(1));
        @(posedge clk); #1;

        // Carry-in to byte 0.
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, lat);
        chk("cin_latency", 64'(lat), 64'(4));
        chk("cin_sum", 64'(sum), 64'h2345_678A);
        chk("cin_cout", 64'(cout), 64'(0));
        @(posedge clk); #1;

        // Backpressure: result held while the sink stalls.
        out_ready = 1'b0;
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, lat);
        chk("bp_latency", 64'(lat), 64'(4));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_sum", 64'(sum), 64'hFFFF_FFFF);
            chk("bp_cout", 64'(cout), 64'(0));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_busy", 64'(busy), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid), 64'(0));
        chk("bp_release_ready", 64'(in_ready), 64'(1));

        // Back-to-back: second set accepted in the DONE cycle of the first.
        a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_first_valid", 64'(out_valid), 64'(1));
        chk("b2b_first_sum", 64'(sum), 64'h0001_0000);
        chk("b2b_first_cout", 64'(cout), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_gap", 64'(n + 1), 64'(5));
        chk("b2b_chain_busy", 64'(busy), 64'(1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("b2b_second_latency", 64'(lat), 64'(4));
        chk("b2b_second_sum", 64'(sum), 64'h0000_0001);
        chk("b2b_second_cout", 64'(cout), 64'(1));
        @(posedge clk); #1;

        // Reset while the third byte is being added.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        #1 rst = 1'b0;
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, lat);
        chk("post_abort_latency", 64'(lat), 64'(4));
        chk("post_abort_sum", 64'(sum), 64'h0000_0002);
        chk("post_abort_cout", 64'(cout), 64'(0));
        @(posedge clk); #1;

`ifdef BSA_SUB_EN
        // Subtraction: cout is NOT borrow, cin ignored.
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
        chk("sub_borrow_sum", 64'(sum), 64'hFFFF_FFFF);
        chk("sub_borrow_cout", 64'(cout), 64'(0));
        @(posedge clk); #1;
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, lat);
        chk("sub_sum", 64'(sum), 64'h0000_0002);
        chk("sub_cout", 64'(cout), 64'(1));
        @(posedge clk); #1;
        op = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder_ctrl.md
# byte_serial_adder_ctrl

Sequencer that performs an NBYTES-wide addition by time-sharing one 8-bit carry look-ahead adder, one byte per clock, least-significant byte first. It chains the carry between bytes through a register. It sits between a valid/ready operand source and a valid/ready result sink, so wide adds reuse the team's existing 8-bit CLA datapath instead of a wide combinational adder.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16; operand width W = 8*NBYTES
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands this cycle
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in to byte 0
- op  input  1  only when BSA_SUB_EN defined; 0 = add, 1 = subtract
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- sum  output  W  result
- cout  output  1  carry out of the top byte
- busy  output  1  high in ADD state

## Operation
- FSM states: IDLE, ADD, DONE. Encoding is 2-bit, with IDLE=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept happens when in_valid && in_ready. On accept:
  - latch a and b
  - carry_q <= cin
  - idx <= 0
  - state <= ADD
- ADD:
  - Adder inputs are a_q[8*idx+:8], b_q[8*idx+:8] and carry_q.
  - sum_q[8*idx+:8] <= adder sum; carry_q <= adder cout.
  - idx increments each cycle.
  - When idx == NBYTES-1, state <= DONE.
- DONE:
  - out_valid=1; sum=sum_q; cout=carry_q.
  - On out_ready with no new accept: go to IDLE.
  - On out_ready with a same-cycle accept: go directly to ADD with the new operands.
  - On !out_ready: hold; sum and cout stay stable.
- in_valid in ADD is ignored; operands are not re-sampled.
- sum and cout keep their last value in IDLE and are only meaningful while out_valid is high.
- Arithmetic is modulo 2^W; cout is the carry out of bit W-1.
- NBYTES=1 means a single ADD cycle.
- idx width is clog2(NBYTES) with a minimum of 1 bit; idx never wraps past NBYTES-1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Internal regs carry_q, idx, a_q and b_q are 0.
- rst asserted mid-ADD or mid-DONE aborts immediately and discards the result. First accept is possible on the first rising edge after rst deasserts.
- Latency: if the accept is at edge k, out_valid rises after edge k+NBYTES.
- Throughput: one result per NBYTES+1 cycles when out_ready is held high, via DONE->ADD chaining.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs except in_ready depending on out_ready in DONE.

## Configuration
- BSA_SUB_EN defined:
  - op port exists and is latched on accept.
  - op=1 feeds ~b byte into the adder and forces carry_q <= 1 on accept, ignoring cin.
  - cout then equals NOT borrow.
- BSA_SUB_EN undefined: no op port; add only.

## Structure
- Shared package holds:
  - the state typedef/localparams (BSA_IDLE, BSA_ADD, BSA_DONE)
  - the clog2 helper for idx width
- One sub-module instance: Carry_Look_Ahead_Adder_8bit (ports a, b, cin, sum, cout), the existing 8-bit CLA, used unmodified.
- The controller contains no other arithmetic.

## Test plan
All cases use NBYTES=4.
- Carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 4 cycles after accept.
- Carry-in: a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
- Backpressure: out_ready=0 for 3 cycles in DONE -> sum/cout stable, in_ready=0, busy=0. Then out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid held high and out_ready=1. Two operand sets accepted 5 cycles apart; the second is accepted in the DONE cycle of the first, and both results are correct.
- Reset abort: rst pulsed while idx=2 -> out_valid=0, sum=0, state IDLE, in_ready=1. Next op 0x1+0x1 -> sum=0x00000002.
- With BSA_SUB_EN: op=1, a=0x00000000, b=0x00000001 -> sum=0xFFFFFFFF, cout=0. Also a=0x5, b=0x3 -> sum=0x00000002, cout=1.
